// File: rtl/puzzle3_ksel_if.sv
`default_nettype none
// ============================================================================
// Module   : puzzle3_ksel_if
// Brief    : Digit stream in, bank results and sticky error flags out.
// Revision : 1.0
// ============================================================================
interface puzzle3_ksel_if #(
    parameter int unsigned SUM_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_digit;
    logic             in_last;
    logic [63:0]      bank_value;
    logic             out_valid;
    logic [SUM_W-1:0] sum;
    logic [15:0]      bank_count;
    logic             err_short;
    logic             err_ovf;

    modport master (
        output in_valid, in_digit, in_last,
        input  in_ready, bank_value, out_valid, sum, bank_count, err_short, err_ovf
    );

    modport slave (
        input  in_valid, in_digit, in_last,
        output in_ready, bank_value, out_valid, sum, bank_count, err_short, err_ovf
    );
endinterface
`default_nettype wire

// File: rtl/puzzle3_ksel.sv
`default_nettype none
// ============================================================================
// Module   : puzzle3_ksel
// Brief    : Buffers a bank of digits, greedily picks the largest K-digit
//            subsequence one position per cycle, and accumulates the result.
// Revision : 1.0
// ============================================================================
module puzzle3_ksel #(
    parameter int unsigned K     = 12,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned SUM_W = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    puzzle3_ksel_if.slave   bus
);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SELECT = 2'd1,
        S_ACCUM  = 2'd2
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [4:0]         i_q;
    logic [LEN_W-1:0]   pos_q;
    logic [LEN_W-1:0]   bpos_q;
    logic [3:0]         best_q;
    logic [63:0]        value_q;
    logic [SUM_W-1:0]   sum_q;
    logic [63:0]        bank_value_q;
    logic [15:0]        bank_count_q;
    logic               out_valid_q;
    logic               err_short_q;
    logic               err_ovf_q;
    logic [3:0]         mem_q [0:DEPTH-1];

    logic               xfer_d;
    logic               room_d;
    logic [LEN_W-1:0]   len_d;
    logic [3:0]         dig_d;
    logic [31:0]        win_end_d;
    logic               take_d;
    logic [3:0]         best_d;
    logic [LEN_W-1:0]   bpos_d;
    logic               scan_end_d;
    logic               last_sel_d;

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.bank_value = bank_value_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sum        = sum_q;
    assign bus.bank_count = bank_count_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_ovf    = err_ovf_q;

    assign xfer_d     = bus.in_valid && (state_q == S_LOAD);
    assign room_d     = (32'(len_q) < DEPTH);
    assign len_d      = room_d ? (len_q + LEN_W'(1)) : len_q;

    // bpos_q starts each scan at the window start, so strict '>' keeps the earliest maximum.
    assign dig_d      = mem_q[pos_q[IDX_W-1:0]];
    assign win_end_d  = 32'(len_q) - K + 32'(i_q);
    assign take_d     = (dig_d > best_q);
    assign best_d     = take_d ? dig_d : best_q;
    assign bpos_d     = take_d ? pos_q : bpos_q;
    assign scan_end_d = (32'(pos_q) == win_end_d) || (dig_d == 4'd9);
    assign last_sel_d = ((32'(i_q) + 32'd1) == K);

    always_ff @(posedge clk) begin
        if ((state_q == S_LOAD) && xfer_d && room_d) begin
            mem_q[len_q[IDX_W-1:0]] <= bus.in_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            len_q        <= '0;
            i_q          <= '0;
            pos_q        <= '0;
            bpos_q       <= '0;
            best_q       <= '0;
            value_q      <= '0;
            sum_q        <= '0;
            bank_value_q <= '0;
            bank_count_q <= '0;
            out_valid_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (xfer_d) begin
                        if (!room_d) begin
                            err_ovf_q <= 1'b1;
                        end
                        if (bus.in_last) begin
                            if (32'(len_d) < K) begin
                                err_short_q <= 1'b1;
                                len_q       <= '0;
                            end else begin
                                len_q   <= len_d;
                                state_q <= S_SELECT;
                                i_q     <= '0;
                                pos_q   <= '0;
                                bpos_q  <= '0;
                                best_q  <= '0;
                                value_q <= '0;
                            end
                        end else begin
                            len_q <= len_d;
                        end
                    end
                end
                S_SELECT: begin
                    if (scan_end_d) begin
                        value_q <= (value_q * 64'd10) + 64'(best_d);
                        pos_q   <= bpos_d + LEN_W'(1);
                        bpos_q  <= bpos_d + LEN_W'(1);
                        best_q  <= '0;
                        i_q     <= i_q + 5'd1;
                        if (last_sel_d) begin
                            state_q <= S_ACCUM;
                        end
                    end else begin
                        pos_q  <= pos_q + LEN_W'(1);
                        best_q <= best_d;
                        bpos_q <= bpos_d;
                    end
                end
                S_ACCUM: begin
                    sum_q        <= sum_q + SUM_W'(value_q);
                    bank_value_q <= value_q;
                    bank_count_q <= bank_count_q + 16'd1;
                    out_valid_q  <= 1'b1;
                    len_q        <= '0;
                    state_q      <= S_LOAD;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
